// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the round-robin memory
//               controller (FSM state encoding, memory direction values).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Controller sequencing states; the encoding is fixed so state can be
    // observed directly on a logic analyser.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Memory direction encoding on rd_wr lines.
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. The grant is combinational from
//               the current requests and the last winner; the last winner is
//               only updated when the caller accepts the grant (grant_en).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       last_gnt
);

    logic r_last_gnt;

    // Pick a winner: a lone request wins outright, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the accepted winner; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (grant_en && (req != 2'b00)) begin
            r_last_gnt <= gnt[1];
        end
    end

    assign last_gnt = r_last_gnt;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_ctrl
// Description : Two-requester round-robin controller for a small binary-cell
//               memory. Each access runs SETUP (address/data settle, enable
//               low), ACCESS (enable high for ACC_CYC cycles, read captured
//               on the closing edge) and DONE (one-cycle ack). All outputs
//               are registered. ACC_CYC must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 4,
    parameter int ACC_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_rd_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wr_data0,
    input  logic [DATA_W-1:0] req_wr_data1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int                CNT_W      = $clog2(ACC_CYC + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(ACC_CYC - 1);

    state_t              r_state;
    logic                r_cmd_rd_wr;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wr_data;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_busy;
    logic                r_mem_en;
    logic                r_mem_rd_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wr_data;

    logic [1:0]          w_gnt;
    logic                w_last_gnt;
    logic                w_grant_en;
    logic                w_sel_rd_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wr_data;

    // Requests are only considered while idle; this also freezes last_gnt,
    // so for the rest of the transaction it names the current winner.
    assign w_grant_en = (r_state == IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (w_grant_en),
        .gnt      (w_gnt),
        .last_gnt (w_last_gnt)
    );

    // Winner's command, selected from the one-hot grant.
    always_comb begin
        w_sel_rd_wr   = w_gnt[1] ? req_rd_wr[1] : req_rd_wr[0];
        w_sel_addr    = w_gnt[1] ? req_addr1    : req_addr0;
        w_sel_wr_data = w_gnt[1] ? req_wr_data1 : req_wr_data0;
    end

    // Access sequencer: command latch, enable timing, read capture and ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cmd_rd_wr   <= RD;
            r_cmd_addr    <= '0;
            r_cmd_wr_data <= '0;
            r_acc_cnt     <= '0;
            r_ack         <= 2'b00;
            r_rd_data     <= '0;
            r_busy        <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_rd_wr   <= RD;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_cmd_rd_wr   <= w_sel_rd_wr;
                        r_cmd_addr    <= w_sel_addr;
                        r_cmd_wr_data <= w_sel_wr_data;
                        // Present the command during SETUP with enable low.
                        r_mem_rd_wr   <= w_sel_rd_wr;
                        r_mem_addr    <= w_sel_addr;
                        r_mem_wr_data <= w_sel_wr_data;
                        r_mem_en      <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SETUP;
                    end
                end
                SETUP: begin
                    r_mem_rd_wr   <= r_cmd_rd_wr;
                    r_mem_addr    <= r_cmd_addr;
                    r_mem_wr_data <= r_cmd_wr_data;
                    r_mem_en      <= 1'b1;
                    r_acc_cnt     <= C_CNT_LOAD;
                    r_state       <= ACCESS;
                end
                ACCESS: begin
                    if (r_acc_cnt == '0) begin
                        // Closing edge: capture before the memory releases its bus.
                        if (r_cmd_rd_wr == RD) begin
                            r_rd_data <= mem_rd_data;
                        end
                        r_mem_en    <= 1'b0;
                        r_mem_rd_wr <= RD;
                        r_ack       <= w_last_gnt ? 2'b10 : 2'b01;
                        r_state     <= DONE;
                    end else begin
                        r_acc_cnt <= r_acc_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_en    <= 1'b0;
                    r_mem_rd_wr <= RD;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign mem_en      = r_mem_en;
    assign mem_rd_wr   = r_mem_rd_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;

endmodule : mem_rr_ctrl
`default_nettype wire

// File: tb/tb_mem_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rr_ctrl
// Description : Directed self-checking bench for mem_rr_ctrl. One instance
//               uses the default ACC_CYC=1, a second uses ACC_CYC=3. Each
//               instance is attached to a small behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_ctrl;

    logic clk;
    logic rst;

    // Instance A (ACC_CYC = 1)
    logic [1:0] req_a, rd_wr_a, ack_a;
    logic [1:0] addr0_a, addr1_a, mem_addr_a;
    logic [3:0] wd0_a, wd1_a, rd_data_a, mem_wr_data_a;
    logic       busy_a, mem_en_a, mem_rd_wr_a;
    wire  [3:0] mem_rd_data_a;
    logic [3:0] mem_a [4];

    // Instance B (ACC_CYC = 3)
    logic [1:0] req_b, rd_wr_b, ack_b;
    logic [1:0] addr0_b, addr1_b, mem_addr_b;
    logic [3:0] wd0_b, wd1_b, rd_data_b, mem_wr_data_b;
    logic       busy_b, mem_en_b, mem_rd_wr_b;
    wire  [3:0] mem_rd_data_b;
    logic [3:0] mem_b [4];

    int n_assert = 0;
    int n_fail   = 0;
    int cnt0     = 0;
    int cnt1     = 0;

    mem_rr_ctrl #(.ADDR_W(2), .DATA_W(4), .ACC_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .req(req_a), .req_rd_wr(rd_wr_a),
        .req_addr0(addr0_a), .req_addr1(addr1_a),
        .req_wr_data0(wd0_a), .req_wr_data1(wd1_a),
        .ack(ack_a), .rd_data(rd_data_a), .busy(busy_a),
        .mem_en(mem_en_a), .mem_rd_wr(mem_rd_wr_a), .mem_addr(mem_addr_a),
        .mem_wr_data(mem_wr_data_a), .mem_rd_data(mem_rd_data_a)
    );

    mem_rr_ctrl #(.ADDR_W(2), .DATA_W(4), .ACC_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req_b), .req_rd_wr(rd_wr_b),
        .req_addr0(addr0_b), .req_addr1(addr1_b),
        .req_wr_data0(wd0_b), .req_wr_data1(wd1_b),
        .ack(ack_b), .rd_data(rd_data_b), .busy(busy_b),
        .mem_en(mem_en_b), .mem_rd_wr(mem_rd_wr_b), .mem_addr(mem_addr_b),
        .mem_wr_data(mem_wr_data_b), .mem_rd_data(mem_rd_data_b)
    );

    // Behavioural memories: drive data only while enabled, write on enable+WR.
    assign mem_rd_data_a = mem_en_a ? mem_a[mem_addr_a] : 4'bz;
    assign mem_rd_data_b = mem_en_b ? mem_b[mem_addr_b] : 4'bz;

    always @(posedge clk) begin
        if (mem_en_a && !mem_rd_wr_a) mem_a[mem_addr_a] <= mem_wr_data_a;
        if (mem_en_b && !mem_rd_wr_b) mem_b[mem_addr_b] <= mem_wr_data_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Acks must never overlap on either instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("ack_a_not_both", 32'(ack_a == 2'b11), 0);
            check("ack_b_not_both", 32'(ack_b == 2'b11), 0);
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 4'h0;
            mem_b[i] = 4'h0;
        end
        mem_b[3] = 4'h5;
        rst = 1'b1;
        req_a = 2'b00; rd_wr_a = 2'b11; addr0_a = 2'd0; addr1_a = 2'd0; wd0_a = 4'h0; wd1_a = 4'h0;
        req_b = 2'b00; rd_wr_b = 2'b11; addr0_b = 2'd0; addr1_b = 2'd0; wd0_b = 4'h0; wd1_b = 4'h0;
        tick(2);
        rst = 1'b0;

        // ---- Reset state
        check("rst_state",   32'(u_dut.r_state), 0);
        check("rst_busy",    32'(busy_a), 0);
        check("rst_ack",     32'(ack_a), 0);
        check("rst_mem_en",  32'(mem_en_a), 0);
        check("rst_rd_wr",   32'(mem_rd_wr_a), 1);
        check("rst_addr",    32'(mem_addr_a), 0);
        check("rst_wdata",   32'(mem_wr_data_a), 0);
        check("rst_rd_data", 32'(rd_data_a), 0);

        // ---- Single write: requester 0 writes addr 2 = A
        req_a = 2'b01; rd_wr_a = 2'b10; addr0_a = 2'd2; wd0_a = 4'hA;
        tick();
        check("wr_setup_en",    32'(mem_en_a), 0);
        check("wr_setup_addr",  32'(mem_addr_a), 2);
        check("wr_setup_data",  32'(mem_wr_data_a), 'hA);
        check("wr_setup_rdwr",  32'(mem_rd_wr_a), 0);
        check("wr_setup_busy",  32'(busy_a), 1);
        check("wr_setup_ack",   32'(ack_a), 0);
        tick();
        check("wr_access_en",   32'(mem_en_a), 1);
        check("wr_access_ack",  32'(ack_a), 0);
        tick();
        check("wr_done_ack",    32'(ack_a), 'b01);
        check("wr_done_en",     32'(mem_en_a), 0);
        check("wr_done_rdwr",   32'(mem_rd_wr_a), 1);
        check("wr_mem_word",    32'(mem_a[2]), 'hA);
        req_a = 2'b00;
        tick();
        check("wr_idle_ack",    32'(ack_a), 0);
        check("wr_idle_busy",   32'(busy_a), 0);

        // ---- Read back addr 2
        req_a = 2'b01; rd_wr_a = 2'b11; addr0_a = 2'd2;
        tick();
        check("rd_setup_en",    32'(mem_en_a), 0);
        check("rd_setup_rdwr",  32'(mem_rd_wr_a), 1);
        tick();
        check("rd_access_en",   32'(mem_en_a), 1);
        tick();
        check("rd_done_ack",    32'(ack_a), 'b01);
        check("rd_done_data",   32'(rd_data_a), 'hA);
        check("rd_done_en",     32'(mem_en_a), 0);
        req_a = 2'b00;
        tick();

        // ---- Simultaneous requests after reset: 0 first (ack cycle 3), 1 next (cycle 7)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 2'b11; rd_wr_a = 2'b00;
        addr0_a = 2'd0; wd0_a = 4'h3;
        addr1_a = 2'd1; wd1_a = 4'h6;
        tick();
        check("sim_first_addr", 32'(mem_addr_a), 0);
        tick(2);
        check("sim_ack_c3",     32'(ack_a), 'b01);
        req_a = 2'b10;
        tick(3);
        check("sim_second_addr", 32'(mem_addr_a), 1);
        check("sim_c6_en",       32'(mem_en_a), 1);
        tick();
        check("sim_ack_c7",      32'(ack_a), 'b10);
        check("sim_mem0",        32'(mem_a[0]), 'h3);
        check("sim_mem1",        32'(mem_a[1]), 'h6);
        req_a = 2'b00;
        tick();

        // ---- Fairness: both hold req for 8 reads; grants alternate 0,1,...
        req_a = 2'b11; rd_wr_a = 2'b11; addr0_a = 2'd2; addr1_a = 2'd1;
        for (int i = 0; i < 8; i++) begin
            tick(3);
            check("fair_ack",  32'(ack_a), (i % 2 == 0) ? 'b01 : 'b10);
            check("fair_data", 32'(rd_data_a), (i % 2 == 0) ? 'hA : 'h6);
            if (ack_a == 2'b01) cnt0++;
            if (ack_a == 2'b10) cnt1++;
            if (i == 7) req_a = 2'b00;
            tick();
            check("fair_ack_low", 32'(ack_a), 0);
        end
        check("fair_cnt0", 32'(cnt0), 4);
        check("fair_cnt1", 32'(cnt1), 4);

        // ---- Isolation: command changes and req drop after grant are ignored
        req_a = 2'b10; rd_wr_a = 2'b10; addr1_a = 2'd1;
        tick();
        check("iso_setup_addr", 32'(mem_addr_a), 1);
        req_a = 2'b00;
        tick();
        addr1_a = 2'd3;
        check("iso_access_en", 32'(mem_en_a), 1);
        tick();
        check("iso_addr_held", 32'(mem_addr_a), 1);
        check("iso_ack",       32'(ack_a), 'b10);
        check("iso_data",      32'(rd_data_a), 'h6);
        tick();
        check("iso_idle_busy", 32'(busy_a), 0);

        // ---- Reset during ACCESS of a write to addr 1
        req_a = 2'b01; rd_wr_a = 2'b10; addr0_a = 2'd1; wd0_a = 4'hF;
        tick(2);
        check("rst_mid_en_before", 32'(mem_en_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 2'b00;
        check("rst_mid_en",    32'(mem_en_a), 0);
        check("rst_mid_state", 32'(u_dut.r_state), 0);
        check("rst_mid_ack",   32'(ack_a), 0);
        check("rst_mid_busy",  32'(busy_a), 0);
        check("rst_mid_rdwr",  32'(mem_rd_wr_a), 1);
        check("rst_mid_addr",  32'(mem_addr_a), 0);
        check("rst_mid_wdata", 32'(mem_wr_data_a), 0);
        check("rst_mid_rdata", 32'(rd_data_a), 0);
        tick();
        check("rst_mid_no_ack", 32'(ack_a), 0);

        // ---- ACC_CYC = 3: read addr 3 (preloaded 5)
        req_b = 2'b01; rd_wr_b = 2'b11; addr0_b = 2'd3;
        tick();
        check("acc3_setup_en", 32'(mem_en_b), 0);
        req_b = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("acc3_en_high", 32'(mem_en_b), 1);
            check("acc3_no_ack",  32'(ack_b), 0);
        end
        tick();
        check("acc3_ack_c5", 32'(ack_b), 'b01);
        check("acc3_data",   32'(rd_data_b), 'h5);
        check("acc3_en_low", 32'(mem_en_b), 0);
        tick();
        check("acc3_idle_busy", 32'(busy_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mem_rr_ctrl
`default_nettype wire
